// File: rtl/uart_pkg.sv
// Shared UART constants: byte width and default receive FIFO depth.
// Used by the UART receiver, transmitter and the receive FIFO.
package uart_pkg;

  localparam int UART_BYTE_W     = 8;
  localparam int UART_FIFO_DEPTH = 8;

  typedef logic [UART_BYTE_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Storage array for the UART receive FIFO: DEPTH x byte, one synchronous
// write port and one asynchronous (combinational) read port. No reset on the
// array; contents are only meaningful where the owning FIFO says so.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_Clock,
  input  logic             i_Wr_En,
  input  logic [AW-1:0]    i_Wr_Addr,
  input  uart_byte_t       i_Wr_Data,
  input  logic [AW-1:0]    i_Rd_Addr,
  output uart_byte_t       o_Rd_Data
);

  uart_byte_t mem [DEPTH];

  // Write the addressed entry on an enabled clock edge.
  always_ff @(posedge i_Clock) begin
    if (i_Wr_En) begin
      mem[i_Wr_Addr] <= i_Wr_Data;
    end
  end

  // Read is combinational so the head entry falls through to the FIFO output.
  always_comb begin
    o_Rd_Data = mem[i_Rd_Addr];
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO with first-word fall-through read, sticky overrun flag
// and optional level interrupt.
// Optional feature macro: UART_RX_FIFO_IRQ_EN adds port o_Irq, driven by a
// register of (o_Count >= IRQ_THRESH) OR o_Overrun.
//
// Handshake: i_Rx_DV is a one-cycle strobe with no ready back-pressure; the
// byte is accepted on that edge if there is room (or a pop frees a slot in
// the same edge), otherwise it is dropped and o_Overrun is set. i_Rd_En pops
// the head on the edge it is high, but only when o_Empty=0; o_Rd_Data always
// shows the current head (8'h00 while empty).
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH      = UART_FIFO_DEPTH,
  parameter int IRQ_THRESH = 1
) (
  input  logic                       i_Clock,
  input  logic                       i_Rst_n,
  input  logic                       i_Rx_DV,
  input  uart_byte_t                 i_Rx_Byte,
  input  logic                       i_Rd_En,
  output uart_byte_t                 o_Rd_Data,
  output logic                       o_Empty,
  output logic                       o_Full,
  output logic [$clog2(DEPTH):0]     o_Count,
  input  logic                       i_Clr_Ovr,
  output logic                       o_Overrun
`ifdef UART_RX_FIFO_IRQ_EN
  ,
  output logic                       o_Irq
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // Reject out-of-range threshold at elaboration time.
  if (IRQ_THRESH < 1 || IRQ_THRESH > DEPTH) begin : g_bad_thresh
    $error("uart_rx_fifo: IRQ_THRESH must be within 1..DEPTH");
  end

  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          ovr_q;
  logic          empty;
  logic          full;
  logic          pop_ok;
  logic          push_ok;
  logic          overrun_evt;
  uart_byte_t    mem_rdata;

  // Flags and accept decisions, all from registered count.
  always_comb begin
    empty       = (count_q == '0);
    full        = (count_q == FULL_COUNT);
    pop_ok      = i_Rd_En && !empty;
    // A pop on a full FIFO frees the slot the simultaneous push needs.
    push_ok     = i_Rx_DV && (!full || pop_ok);
    overrun_evt = i_Rx_DV && full && !pop_ok;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Occupancy count: unchanged when push and pop both happen.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      count_q <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky overrun; a new overrun beats a clear in the same cycle.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      ovr_q <= 1'b0;
    end else if (overrun_evt) begin
      ovr_q <= 1'b1;
    end else if (i_Clr_Ovr) begin
      ovr_q <= 1'b0;
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .i_Clock   (i_Clock),
    .i_Wr_En   (push_ok),
    .i_Wr_Addr (wr_ptr_q),
    .i_Wr_Data (i_Rx_Byte),
    .i_Rd_Addr (rd_ptr_q),
    .o_Rd_Data (mem_rdata)
  );

  // Head byte falls through; forced to zero while empty so reset shows 8'h00.
  always_comb begin
    o_Rd_Data = empty ? '0 : mem_rdata;
    o_Empty   = empty;
    o_Full    = full;
    o_Count   = count_q;
    o_Overrun = ovr_q;
  end

`ifdef UART_RX_FIFO_IRQ_EN
  localparam logic [CW-1:0] THRESH_COUNT = CW'(IRQ_THRESH);

  logic irq_q;

  // Level interrupt registered one cycle behind the count and overrun state.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= (count_q >= THRESH_COUNT) || ovr_q;
    end
  end

  always_comb begin
    o_Irq = irq_q;
  end
`endif

endmodule
